// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Multi-cycle data-memory responder for the MEM stage of a 64-bit RISC-V
//   pipeline. It accepts a load or store from EX/MEM and holds the pipeline
//   stalled while the access is in flight. It returns size-extended load data
//   for capture into MEM/WB. Storage is little-endian and byte addressable,
//   and it supports byte/half/word/double accesses.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high reset
//   MemRead        in   load request
//   MemWrite       in   store request (wins when both are high)
//   Addr[63:0]     in   byte address; wraps modulo DEPTH_BYTES
//   Write_Data     in   store data; low 1/2/4/8 bytes are used
//   Size[1:0]      in   00 byte, 01 half, 10 word, 11 double
//   Unsigned       in   1 = zero-extend the load, 0 = sign-extend
//   Mem_Busy       out  stall request (combinational)
//   Mem_Done       out  one-cycle completion pulse
//   Read_Data      out  extended load data (registered)
//   Mem_Misaligned out  pulses with Mem_Done on a misaligned access
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_BYTES = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Addr,
    input  logic [63:0] Write_Data,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic        Mem_Busy,
    output logic        Mem_Done,
    output logic [63:0] Read_Data,
    output logic        Mem_Misaligned
);

    // Storage is split into 8 byte lanes of ROWS entries each. Any aligned
    // access lies entirely inside one 8-byte row, so a single row index
    // serves every lane.
    localparam int ROWS = DEPTH_BYTES / 8;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW   = RW + 3;
    localparam int CW   = ($clog2(LATENCY + 1) < 2) ? 2 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;

    // Request captured at acceptance
    logic [AW-1:0]   r_addr;
    logic [63:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_store;
    logic            r_load;
    logic            r_mis;

    logic            w_req;
    logic            w_accept;
    logic            w_access;
    logic            w_unused_addr;

    // Operands of the access performed at this edge
    logic [AW-1:0]   w_a_addr;
    logic [63:0]     w_a_wdata;
    logic [1:0]      w_a_size;
    logic            w_a_uns;
    logic            w_a_store;
    logic            w_a_load;

    logic [2:0]      w_off;
    logic [RW-1:0]   w_row;
    logic [3:0]      w_nbytes;
    logic [3:0]      w_lo;
    logic [3:0]      w_hi;
    logic            w_mis;
    logic            w_do_write;
    logic [63:0]     w_wshift;
    logic [63:0]     w_rrow;
    logic [63:0]     w_rshift;
    logic [63:0]     w_ext;

    assign w_req         = MemRead | MemWrite;
    assign w_unused_addr = ^Addr[63:AW];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and control outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        Mem_Busy     = 1'b0;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    Mem_Busy = 1'b1;
                    w_accept = 1'b1;
                    // With a one-cycle latency there is no BUSY cycle: the
                    // access happens at the acceptance edge.
                    if (LATENCY == 1) begin
                        w_access     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                Mem_Busy = 1'b1;
                // Counter decrements to 1 at this edge: do the access now.
                if (r_count == CW'(2)) begin
                    w_access     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Requests seen here belong to the instruction now retiring.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Latency counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CW'(LATENCY);
        end else if (r_state == S_BUSY) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Request capture (no reset needed; only consumed after acceptance)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= Addr[AW-1:0];
            r_wdata <= Write_Data;
            r_size  <= Size;
            r_uns   <= Unsigned;
            r_store <= MemWrite;
            r_load  <= MemRead & ~MemWrite;
        end
    end

    // In IDLE the live inputs are the access operands (LATENCY==1 path);
    // otherwise the captured copy is used.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_a_addr  = Addr[AW-1:0];
            w_a_wdata = Write_Data;
            w_a_size  = Size;
            w_a_uns   = Unsigned;
            w_a_store = MemWrite;
            w_a_load  = MemRead & ~MemWrite;
        end else begin
            w_a_addr  = r_addr;
            w_a_wdata = r_wdata;
            w_a_size  = r_size;
            w_a_uns   = r_uns;
            w_a_store = r_store;
            w_a_load  = r_load;
        end
    end

    // ---------------------------------------------------------------------
    // Address decode and alignment
    // ---------------------------------------------------------------------
    assign w_off    = w_a_addr[2:0];
    assign w_row    = w_a_addr[AW-1:3] & RW'(ROWS - 1);
    assign w_nbytes = 4'd1 << w_a_size;
    assign w_lo     = {1'b0, w_off};
    assign w_hi     = w_lo + w_nbytes;

    always_comb begin
        case (w_a_size)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = w_off[0];
            2'b10:   w_mis = |w_off[1:0];
            default: w_mis = |w_off;
        endcase
    end

    // Reset at the access edge aborts the access, so storage stays intact.
    assign w_do_write = w_access & w_a_store & ~w_mis & ~reset;
    assign w_wshift   = w_a_wdata << {w_off, 3'b000};

    // ---------------------------------------------------------------------
    // Byte-lane storage
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_bank [ROWS];
            logic       w_be;

            assign w_be = (4'(gi) >= w_lo) && (4'(gi) < w_hi);

            always_ff @(posedge clk) begin
                if (w_do_write && w_be) begin
                    r_bank[w_row] <= w_wshift[8*gi +: 8];
                end
            end

            assign w_rrow[8*gi +: 8] = r_bank[w_row];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Load extraction and extension
    // ---------------------------------------------------------------------
    assign w_rshift = w_rrow >> {w_off, 3'b000};

    always_comb begin
        case (w_a_size)
            2'b00:   w_ext = w_a_uns ? {56'd0, w_rshift[7:0]}
                                     : {{56{w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   w_ext = w_a_uns ? {48'd0, w_rshift[15:0]}
                                     : {{48{w_rshift[15]}}, w_rshift[15:0]};
            2'b10:   w_ext = w_a_uns ? {32'd0, w_rshift[31:0]}
                                     : {{32{w_rshift[31]}}, w_rshift[31:0]};
            default: w_ext = w_rshift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Read_Data <= 64'd0;
        end else if (w_access && w_a_load && !w_mis) begin
            Read_Data <= w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis <= 1'b0;
        end else if (w_access) begin
            r_mis <= w_mis;
        end
    end

    assign Mem_Done       = (r_state == S_DONE);
    assign Mem_Misaligned = (r_state == S_DONE) & r_mis;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder (DEPTH_BYTES=256, LATENCY=2).
// A byte-array model computes the expected load data, misalignment flags and
// handshake timing. A negedge compare process checks every DUT output on each
// cycle. A few literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Addr;
    logic [63:0] Write_Data;
    logic [1:0]  Size;
    logic        Unsigned;
    logic        Mem_Busy;
    logic        Mem_Done;
    logic [63:0] Read_Data;
    logic        Mem_Misaligned;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Addr          (Addr),
        .Write_Data    (Write_Data),
        .Size          (Size),
        .Unsigned      (Unsigned),
        .Mem_Busy      (Mem_Busy),
        .Mem_Done      (Mem_Done),
        .Read_Data     (Read_Data),
        .Mem_Misaligned(Mem_Misaligned)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    int          cyc      = 0;

    logic [7:0]  mem_model [DEPTH];
    logic        exp_busy;
    logic        exp_done;
    logic        exp_mis;
    logic [63:0] exp_rd;

    // Per-cycle comparison of all outputs against the model expectations
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            checks++;
            if (Mem_Busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, Mem_Busy, exp_busy);
            end
            checks++;
            if (Mem_Done !== exp_done) begin
                failures++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, Mem_Done, exp_done);
            end
            checks++;
            if (Mem_Misaligned !== exp_mis) begin
                failures++;
                $display("FAIL misaligned cyc=%0d got=%b exp=%b", cyc, Mem_Misaligned, exp_mis);
            end
            checks++;
            if (Read_Data !== exp_rd) begin
                failures++;
                $display("FAIL read_data cyc=%0d got=%h exp=%h", cyc, Read_Data, exp_rd);
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Addr       = 64'd0;
        Write_Data = 64'd0;
        Size       = 2'b00;
        Unsigned   = 1'b0;
    endtask

    // Called at the start of a cycle (posedge + 1). Returns at the start of
    // the cycle after DONE, with inputs idle.
    task automatic run_req(input logic rd, input logic wr, input logic [63:0] a,
                           input logic [63:0] wd, input logic [1:0] sz,
                           input logic uns, input bit hold);
        int          n;
        int          idx;
        bit          mis;
        logic [63:0] v;
        n   = 1 << sz;
        idx = int'(a % DEPTH);
        mis = (a % n) != 0;
        MemRead    = rd;
        MemWrite   = wr;
        Addr       = a;
        Write_Data = wd;
        Size       = sz;
        Unsigned   = uns;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_mis  = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
        end
        // DONE cycle
        if (!mis) begin
            if (wr) begin
                for (int k = 0; k < n; k++) mem_model[idx + k] = wd[8*k +: 8];
            end else if (rd) begin
                v = 64'd0;
                for (int k = 0; k < n; k++) v |= 64'(mem_model[idx + k]) << (8 * k);
                if (!uns && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
                exp_rd = v;
            end
        end
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_mis  = mis;
        if (!hold) idle_inputs();
        @(posedge clk); #1;
        idle_inputs();
        exp_done = 1'b0;
        exp_mis  = 1'b0;
        $display("txn rd=%b wr=%b addr=%h wd=%h size=%0d uns=%b mis=%b rd_data=%h",
                 rd, wr, a, wd, sz, uns, mis, Read_Data);
    endtask

    task automatic idle_cycle();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_mis  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_mis  = 1'b0;
        exp_rd   = 64'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check_lit("reset_read_data", Read_Data, 64'd0);
        reset = 1'b0;
        idle_cycle();

        // Double store, then byte loads (signed / unsigned)
        run_req(1'b0, 1'b1, 64'h10, 64'h8877665544332211, 2'b11, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 64'h17, 64'h0, 2'b00, 1'b0, 1'b0);
        check_lit("ld_b_signed", Read_Data, 64'hFFFFFFFFFFFFFF88);
        run_req(1'b1, 1'b0, 64'h17, 64'h0, 2'b00, 1'b1, 1'b0);
        check_lit("ld_b_unsigned", Read_Data, 64'h0000000000000088);
        run_req(1'b1, 1'b0, 64'h10, 64'h0, 2'b00, 1'b1, 1'b0);
        check_lit("ld_b_lowbyte", Read_Data, 64'h11);

        // Half store uses only the low two bytes of Write_Data
        run_req(1'b0, 1'b1, 64'h12, 64'h123456789ABCBEEF, 2'b01, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 64'h10, 64'h0, 2'b11, 1'b0, 1'b0);
        check_lit("ld_d_after_half", Read_Data, 64'h88776655BEEF2211);

        // Misaligned load and store: flag, no data change, same latency
        run_req(1'b1, 1'b0, 64'h13, 64'h0, 2'b10, 1'b0, 1'b0);
        check_lit("mis_load_hold", Read_Data, 64'h88776655BEEF2211);
        run_req(1'b0, 1'b1, 64'h11, 64'hDEADBEEF, 2'b10, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 64'h16, 64'h0, 2'b11, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 64'h10, 64'h0, 2'b11, 1'b0, 1'b0);
        check_lit("mis_store_nochange", Read_Data, 64'h88776655BEEF2211);

        // Wrap-around store with the request held through DONE
        run_req(1'b0, 1'b1, 64'h1_0000_0010, 64'h5A, 2'b00, 1'b0, 1'b1);
        idle_cycle();
        idle_cycle();
        run_req(1'b1, 1'b0, 64'h10, 64'h0, 2'b11, 1'b0, 1'b0);
        check_lit("wrap_store", Read_Data, 64'h88776655BEEF225A);

        // Word and half extensions, back-to-back with no bubble
        run_req(1'b1, 1'b0, 64'h14, 64'h0, 2'b10, 1'b0, 1'b0);
        check_lit("ld_w_signed", Read_Data, 64'hFFFFFFFF88776655);
        run_req(1'b1, 1'b0, 64'h14, 64'h0, 2'b10, 1'b1, 1'b0);
        check_lit("ld_w_unsigned", Read_Data, 64'h0000000088776655);
        run_req(1'b1, 1'b0, 64'h12, 64'h0, 2'b01, 1'b0, 1'b0);
        check_lit("ld_h_signed", Read_Data, 64'hFFFFFFFFFFFFBEEF);
        run_req(1'b1, 1'b0, 64'h12, 64'h0, 2'b01, 1'b1, 1'b0);
        check_lit("ld_h_unsigned", Read_Data, 64'h000000000000BEEF);

        // Reset during BUSY aborts the store to 0x20
        run_req(1'b0, 1'b1, 64'h20, 64'h0123456789ABCDEF, 2'b11, 1'b0, 1'b0);
        MemWrite   = 1'b1;
        Addr       = 64'h20;
        Write_Data = 64'hFFFFFFFFFFFFFFFF;
        Size       = 2'b11;
        exp_busy   = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b1;
        exp_busy = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        exp_rd = 64'd0;
        idle_cycle();
        $display("txn reset abort store addr=20 rd_data=%h", Read_Data);
        check_lit("abort_rd_cleared", Read_Data, 64'd0);
        run_req(1'b1, 1'b0, 64'h20, 64'h0, 2'b00, 1'b1, 1'b0);
        check_lit("abort_byte_kept", Read_Data, 64'hEF);
        run_req(1'b1, 1'b0, 64'h20, 64'h0, 2'b11, 1'b0, 1'b0);
        check_lit("abort_dword_kept", Read_Data, 64'h0123456789ABCDEF);

        // Read and write together act as a store; Read_Data unchanged
        run_req(1'b1, 1'b1, 64'h28, 64'h77, 2'b00, 1'b0, 1'b0);
        check_lit("rw_keeps_rd", Read_Data, 64'h0123456789ABCDEF);
        run_req(1'b1, 1'b0, 64'h28, 64'h0, 2'b00, 1'b1, 1'b0);
        check_lit("rw_stored", Read_Data, 64'h77);

        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
